// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences one load/store at a time between the MEM stage and
// the data RAM. It decodes SPARC op3 into size/sign/direction and rejects illegal
// or misaligned requests without touching memory. It holds the memory handshake
// until mem_mfc arrives or the timeout expires, then returns a one-cycle response
// carrying the extended load data and a fault code.
module mem_access_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [5:0]  op3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic [1:0]  fault,
  output logic        mem_en,
  output logic        mem_rw,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_mfc,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] FLT_OK      = 2'b00;
  localparam logic [1:0] FLT_ALIGN   = 2'b01;
  localparam logic [1:0] FLT_TIMEOUT = 2'b10;
  localparam logic [1:0] FLT_ILLEGAL = 2'b11;

  localparam int            CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

  // op3 decode helpers: legality, access size, direction (1 = read) and sign
  function automatic logic f_legal(input logic [5:0] op);
    case (op)
      6'b001001, 6'b001010, 6'b000001, 6'b000010,
      6'b000000, 6'b000101, 6'b000110, 6'b000100: f_legal = 1'b1;
      default:                                     f_legal = 1'b0;
    endcase
  endfunction

  // illegal op3 reports word size so the memory-side outputs look like the idle default
  function automatic logic [1:0] f_size(input logic [5:0] op);
    case (op)
      6'b001001, 6'b000001, 6'b000101: f_size = SZ_BYTE;
      6'b001010, 6'b000010, 6'b000110: f_size = SZ_HALF;
      default:                         f_size = SZ_WORD;
    endcase
  endfunction

  function automatic logic f_rw(input logic [5:0] op);
    case (op)
      6'b000101, 6'b000110, 6'b000100: f_rw = 1'b0;
      default:                         f_rw = 1'b1;
    endcase
  endfunction

  function automatic logic f_sgn(input logic [5:0] op);
    f_sgn = (op == 6'b001001) || (op == 6'b001010);
  endfunction

  logic [1:0]    r_state;
  logic [1:0]    w_state_next;
  logic [5:0]    r_op3;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_rdata;
  logic [1:0]    r_fault;

  logic          w_in_legal;
  logic [1:0]    w_in_size;
  logic          w_in_misal;
  logic [1:0]    w_lat_size;
  logic          w_lat_rw;
  logic          w_lat_sgn;
  logic          w_timeout;
  logic [31:0]   w_ext_rdata;
  logic [31:0]   w_masked_wdata;

  assign w_in_legal = f_legal(op3);
  assign w_in_size  = f_size(op3);
  assign w_in_misal = ((w_in_size == SZ_HALF) && addr[0]) ||
                      ((w_in_size == SZ_WORD) && (addr[1:0] != 2'b00));
  assign w_lat_size = f_size(r_op3);
  assign w_lat_rw   = f_rw(r_op3);
  assign w_lat_sgn  = f_sgn(r_op3);
  assign w_timeout  = (r_cnt == TMAX);

  // sign/zero extension of the returned read data according to the latched op3
  always_comb begin
    w_ext_rdata = mem_rdata;
    case (w_lat_size)
      SZ_BYTE: w_ext_rdata = {{24{w_lat_sgn & mem_rdata[7]}}, mem_rdata[7:0]};
      SZ_HALF: w_ext_rdata = {{16{w_lat_sgn & mem_rdata[15]}}, mem_rdata[15:0]};
      default: w_ext_rdata = mem_rdata;
    endcase
  end

  // store data with bits above the access size forced to zero
  always_comb begin
    w_masked_wdata = r_wdata;
    case (w_lat_size)
      SZ_BYTE: w_masked_wdata = {24'd0, r_wdata[7:0]};
      SZ_HALF: w_masked_wdata = {16'd0, r_wdata[15:0]};
      default: w_masked_wdata = r_wdata;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // next-state logic: faults on accept skip ACCESS entirely; mfc beats timeout
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (!w_in_legal || w_in_misal) w_state_next = ST_RESP;
          else                           w_state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (mem_mfc || w_timeout) w_state_next = ST_RESP;
      end
      ST_RESP: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // outputs decoded from state and the latched request
  always_comb begin
    req_ready  = (r_state == ST_IDLE);
    mem_en     = (r_state == ST_ACCESS);
    resp_valid = (r_state == ST_RESP);
    rdata      = r_rdata;
    fault      = r_fault;
    mem_rw     = w_lat_rw;
    mem_size   = w_lat_size;
    mem_addr   = r_addr;
    mem_wdata  = w_masked_wdata;
  end

  // request latch, timeout counter and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op3   <= 6'b000000;  // decodes as a word read: the idle memory-side defaults
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_cnt   <= '0;
      r_rdata <= 32'd0;
      r_fault <= FLT_OK;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_op3   <= op3;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_cnt   <= '0;
            if (!w_in_legal) begin
              r_fault <= FLT_ILLEGAL;
              r_rdata <= 32'd0;
            end else if (w_in_misal) begin
              r_fault <= FLT_ALIGN;
              r_rdata <= 32'd0;
            end
          end
        end
        ST_ACCESS: begin
          if (mem_mfc) begin
            r_fault <= FLT_OK;
            r_rdata <= w_lat_rw ? w_ext_rdata : 32'd0;
          end else if (w_timeout) begin
            r_fault <= FLT_TIMEOUT;
            r_rdata <= 32'd0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed testbench for mem_access_ctrl: one task per scenario, inline checks.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [5:0]  op3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] rdata;
  logic [1:0]  fault;
  logic        mem_en;
  logic        mem_rw;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_mfc;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  localparam logic [5:0] OP_LDSB = 6'b001001;
  localparam logic [5:0] OP_LDSH = 6'b001010;
  localparam logic [5:0] OP_LDUB = 6'b000001;
  localparam logic [5:0] OP_LDUH = 6'b000010;
  localparam logic [5:0] OP_LD   = 6'b000000;
  localparam logic [5:0] OP_STB  = 6'b000101;
  localparam logic [5:0] OP_STH  = 6'b000110;
  localparam logic [5:0] OP_ST   = 6'b000100;

  mem_access_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .op3(op3), .addr(addr),
    .wdata(wdata), .req_ready(req_ready), .resp_valid(resp_valid), .rdata(rdata),
    .fault(fault), .mem_en(mem_en), .mem_rw(mem_rw), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mfc(mem_mfc),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // presents one request for a single cycle; the controller must be idle
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1; op3 = op; addr = a; wdata = d;
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp got=%b exp=0", resp_valid); end
    checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL reset_en got=%b exp=0", mem_en); end
    checks++; if (rdata !== 32'd0 || fault !== 2'b00) begin failures++; $display("FAIL reset_rdata_fault got=%h/%b exp=0/00", rdata, fault); end
    checks++; if (mem_rw !== 1'b1 || mem_size !== 2'b10) begin failures++; $display("FAIL reset_rw_size got=%b/%b exp=1/10", mem_rw, mem_size); end
    checks++; if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin failures++; $display("FAIL reset_addr_wdata got=%h/%h exp=0/0", mem_addr, mem_wdata); end
    $display("reset: ready=%b en=%b rw=%b size=%b", req_ready, mem_en, mem_rw, mem_size);
  endtask

  task automatic test_ldsb();
    issue(OP_LDSB, 32'h13, 32'd0);
    checks++; if (mem_en !== 1'b1 || req_ready !== 1'b0) begin failures++; $display("FAIL ldsb_en got=%b/%b exp=1/0", mem_en, req_ready); end
    checks++; if (mem_size !== 2'b00 || mem_rw !== 1'b1 || mem_addr !== 32'h13) begin failures++; $display("FAIL ldsb_bus got=%b/%b/%h exp=00/1/13", mem_size, mem_rw, mem_addr); end
    mem_mfc = 1'b1; mem_rdata = 32'h0000_00F0;
    step();
    mem_mfc = 1'b0;
    checks++; if (resp_valid !== 1'b1 || mem_en !== 1'b0) begin failures++; $display("FAIL ldsb_resp got=%b/%b exp=1/0", resp_valid, mem_en); end
    checks++; if (rdata !== 32'hFFFF_FFF0 || fault !== 2'b00) begin failures++; $display("FAIL ldsb_data got=%h/%b exp=fffffff0/00", rdata, fault); end
    $display("LDSB addr=13: rdata=%h fault=%b", rdata, fault);
    step();
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || rdata !== 32'hFFFF_FFF0) begin failures++; $display("FAIL ldsb_after got=%b/%b/%h exp=0/1/fffffff0", resp_valid, req_ready, rdata); end
  endtask

  task automatic test_lduh_wait();
    int en_cnt = 0;
    issue(OP_LDUH, 32'h22, 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (mem_en === 1'b1) en_cnt++;
      checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL lduh_early_resp cyc=%0d got=%b exp=0", i, resp_valid); end
      if (i == 3) begin mem_mfc = 1'b1; mem_rdata = 32'h0000_8001; end
      step();
    end
    mem_mfc = 1'b0;
    checks++; if (en_cnt != 4) begin failures++; $display("FAIL lduh_en_cycles got=%0d exp=4", en_cnt); end
    checks++; if (resp_valid !== 1'b1 || rdata !== 32'h0000_8001 || fault !== 2'b00) begin failures++; $display("FAIL lduh_resp got=%b/%h/%b exp=1/00008001/00", resp_valid, rdata, fault); end
    $display("LDUH addr=22: en_cycles=%0d rdata=%h", en_cnt, rdata);
    step();
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL lduh_pulse got=%b exp=0", resp_valid); end
  endtask

  task automatic test_timeout();
    int en_cnt = 0;
    int n = 0;
    issue(OP_LD, 32'h100, 32'd0);
    while (resp_valid !== 1'b1 && n < 40) begin
      if (mem_en === 1'b1) en_cnt++;
      step();
      n++;
    end
    checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL timeout_no_resp got=%b exp=1", resp_valid); end
    checks++; if (en_cnt != 16) begin failures++; $display("FAIL timeout_en_cycles got=%0d exp=16", en_cnt); end
    checks++; if (fault !== 2'b10 || rdata !== 32'd0 || mem_en !== 1'b0) begin failures++; $display("FAIL timeout_resp got=%b/%h/%b exp=10/0/0", fault, rdata, mem_en); end
    $display("LD timeout: en_cycles=%0d fault=%b rdata=%h", en_cnt, fault, rdata);
    mem_mfc = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step(); step();
    mem_mfc = 1'b0;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || fault !== 2'b10 || rdata !== 32'd0) begin failures++; $display("FAIL late_mfc got=%b/%b/%b/%h exp=0/1/10/0", resp_valid, req_ready, fault, rdata); end
  endtask

  task automatic test_misaligned_store();
    issue(OP_STH, 32'h41, 32'h1234);
    checks++; if (resp_valid !== 1'b1 || fault !== 2'b01 || mem_en !== 1'b0 || rdata !== 32'd0) begin failures++; $display("FAIL sth_misal got=%b/%b/%b/%h exp=1/01/0/0", resp_valid, fault, mem_en, rdata); end
    $display("STH addr=41: fault=%b", fault);
    step();
    checks++; if (resp_valid !== 1'b0 || mem_en !== 1'b0) begin failures++; $display("FAIL sth_after got=%b/%b exp=0/0", resp_valid, mem_en); end
    issue(OP_ST, 32'h40, 32'hDEAD_BEEF);
    checks++; if (mem_en !== 1'b1 || mem_rw !== 1'b0 || mem_size !== 2'b10 || mem_wdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL st_bus got=%b/%b/%b/%h exp=1/0/10/deadbeef", mem_en, mem_rw, mem_size, mem_wdata); end
    mem_mfc = 1'b1; mem_rdata = 32'h5555_5555;
    step();
    mem_mfc = 1'b0;
    checks++; if (resp_valid !== 1'b1 || fault !== 2'b00 || rdata !== 32'd0) begin failures++; $display("FAIL st_resp got=%b/%b/%h exp=1/00/0", resp_valid, fault, rdata); end
    $display("ST addr=40: wdata=deadbeef fault=%b", fault);
    step();
    issue(OP_STB, 32'h43, 32'h1234_5678);
    checks++; if (mem_size !== 2'b00 || mem_wdata !== 32'h0000_0078 || mem_addr !== 32'h43) begin failures++; $display("FAIL stb_mask got=%b/%h/%h exp=00/00000078/43", mem_size, mem_wdata, mem_addr); end
    mem_mfc = 1'b1;
    step();
    mem_mfc = 1'b0;
    step();
    $display("STB addr=43: mem_wdata masked");
  endtask

  task automatic test_illegal();
    issue(6'h3F, 32'h0, 32'd0);
    checks++; if (resp_valid !== 1'b1 || fault !== 2'b11 || mem_en !== 1'b0) begin failures++; $display("FAIL illegal got=%b/%b/%b exp=1/11/0", resp_valid, fault, mem_en); end
    $display("op3=3f: fault=%b", fault);
    step();
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1; op3 = OP_LDUB; addr = 32'h5; wdata = 32'd0;
    step();
    checks++; if (req_ready !== 1'b0 || mem_en !== 1'b1 || mem_addr !== 32'h5) begin failures++; $display("FAIL b2b_first got=%b/%b/%h exp=0/1/5", req_ready, mem_en, mem_addr); end
    op3 = OP_LDSH; addr = 32'h6;
    mem_mfc = 1'b1; mem_rdata = 32'h0000_01AB;
    step();
    mem_mfc = 1'b0;
    checks++; if (resp_valid !== 1'b1 || req_ready !== 1'b0 || rdata !== 32'h0000_00AB) begin failures++; $display("FAIL b2b_resp1 got=%b/%b/%h exp=1/0/000000ab", resp_valid, req_ready, rdata); end
    $display("b2b LDUB addr=5: rdata=%h", rdata);
    step();
    checks++; if (req_ready !== 1'b1 || mem_en !== 1'b0 || resp_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b/%b/%b exp=1/0/0", req_ready, mem_en, resp_valid); end
    step();
    req_valid = 1'b0;
    checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h6 || mem_size !== 2'b01) begin failures++; $display("FAIL b2b_second got=%b/%h/%b exp=1/6/01", mem_en, mem_addr, mem_size); end
    mem_mfc = 1'b1; mem_rdata = 32'h0000_8001;
    step();
    mem_mfc = 1'b0;
    checks++; if (resp_valid !== 1'b1 || rdata !== 32'hFFFF_8001) begin failures++; $display("FAIL b2b_resp2 got=%b/%h exp=1/ffff8001", resp_valid, rdata); end
    $display("b2b LDSH addr=6: rdata=%h", rdata);
    step();
  endtask

  task automatic test_reset_mid();
    issue(OP_LD, 32'h8, 32'd0);
    checks++; if (mem_en !== 1'b1) begin failures++; $display("FAIL rstmid_en got=%b exp=1", mem_en); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (mem_en !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin failures++; $display("FAIL rstmid_state got=%b/%b/%b exp=0/1/0", mem_en, req_ready, resp_valid); end
    checks++; if (mem_addr !== 32'd0 || rdata !== 32'd0 || fault !== 2'b00 || mem_size !== 2'b10) begin failures++; $display("FAIL rstmid_regs got=%h/%h/%b/%b exp=0/0/00/10", mem_addr, rdata, fault, mem_size); end
    mem_mfc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rstmid_noresp cyc=%0d got=%b exp=0", i, resp_valid); end
      step();
    end
    mem_mfc = 1'b0;
    $display("reset mid-access: en=%b ready=%b", mem_en, req_ready);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; op3 = 6'd0; addr = 32'd0; wdata = 32'd0;
    mem_mfc = 1'b0; mem_rdata = 32'd0;
    #1;
    test_reset();
    test_ldsb();
    test_lduh_wait();
    test_timeout();
    test_misaligned_store();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
